// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared owner-state and source encodings for the round-robin mux arbiter.
package mux_arb_pkg;
    typedef enum logic [1:0] {OWN_IDLE, OWN_A, OWN_B} owner_e;
    typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e;
endpackage

// File: rtl/mux_arb_grant.sv
// mux_arb_grant: combinational grant decision from owner state, burst count and request valids.
module mux_arb_grant
    import mux_arb_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  owner_e           state_i,
    input  logic [CNT_W-1:0] burst_cnt_i,
    input  logic             a_valid_i,
    input  logic             b_valid_i,
    output src_e             grant_o,
    output logic             has_grant_o
);
    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_BURST);
    logic exhausted;
    src_e contended;
    always_comb begin
        exhausted   = burst_cnt_i >= MaxCnt;
        // Under contention the owner keeps the mux until its burst is used up.
        contended   = state_i == OWN_B ? (exhausted ? SRC_A : SRC_B) :
                      state_i == OWN_A ? (exhausted ? SRC_B : SRC_A) : SRC_A;
        grant_o     = (a_valid_i && b_valid_i) ? contended : (b_valid_i ? SRC_B : SRC_A);
        has_grant_o = a_valid_i || b_valid_i;
    end
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: two valid/ready requesters share one registered 2:1 mux,
// sequenced by a round-robin owner FSM with a per-owner burst limit.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_valid_i,
    input  logic [DATA_W-1:0] a_data_i,
    output logic              a_ready_o,
    input  logic              b_valid_i,
    input  logic [DATA_W-1:0] b_data_i,
    output logic              b_ready_o,
    output logic              y_valid_o,
    output logic [DATA_W-1:0] y_data_o,
    output logic              y_src_o,
    input  logic              y_ready_i
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_BURST);

    owner_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              y_valid_q, y_valid_d;
    logic [DATA_W-1:0] y_data_q, y_data_d;
    src_e              y_src_q, y_src_d, grant;
    logic              has_grant, can_load, xfer, same_owner;

    mux_arb_grant #(.MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) u_grant (
        .state_i    (state_q),
        .burst_cnt_i(cnt_q),
        .a_valid_i  (a_valid_i),
        .b_valid_i  (b_valid_i),
        .grant_o    (grant),
        .has_grant_o(has_grant)
    );

    always_comb begin
        can_load   = !y_valid_q || y_ready_i;
        xfer       = can_load && has_grant;
        same_owner = (grant == SRC_A && state_q == OWN_A) || (grant == SRC_B && state_q == OWN_B);
        state_d    = !xfer ? state_q : (grant == SRC_B ? OWN_B : OWN_A);
        cnt_d      = !xfer ? cnt_q : !same_owner ? CNT_W'(1) :
                     (cnt_q == MaxCnt ? cnt_q : cnt_q + CNT_W'(1));
        y_valid_d  = xfer || (y_valid_q && !y_ready_i);
        y_data_d   = xfer ? (grant == SRC_B ? b_data_i : a_data_i) : y_data_q;
        y_src_d    = xfer ? grant : y_src_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= OWN_IDLE;
            cnt_q     <= '0;
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
            y_src_q   <= SRC_A;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            y_valid_q <= y_valid_d;
            y_data_q  <= y_data_d;
            y_src_q   <= y_src_d;
        end
    end

    // Readies are forced low while reset is held, since can_load is 1 then.
    assign a_ready_o = reset_n && xfer && grant == SRC_A;
    assign b_ready_o = reset_n && xfer && grant == SRC_B;
    assign y_valid_o = y_valid_q;
    assign y_data_o  = y_data_q;
    assign y_src_o   = y_src_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: table-driven and scoreboarded checks of the round-robin mux arbiter.
module tb_mux_rr_arbiter;
    import mux_arb_pkg::*;

    logic       clk = 1'b0, reset_n = 1'b0;
    logic       a_valid = 1'b0, b_valid = 1'b0, y_ready = 1'b0;
    logic [7:0] a_data = '0, b_data = '0;
    logic       a_ready, b_ready, y_valid, y_src;
    logic [7:0] y_data;
    logic       a_ready1, b_ready1, y_valid1, y_src1;
    logic [7:0] y_data1;

    int n_chk = 0, n_fail = 0;
    typedef struct packed {logic [7:0] d; logic s;} exp_t;
    exp_t sb[$];
    int   ms, mc;
    logic my_v;

    typedef struct {logic av; logic [7:0] ad; logic bv; logic [7:0] bd; logic yr; logic src;} vec_t;
    vec_t tbl[12];

    always #5 clk = ~clk;

    mux_rr_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid_i(a_valid), .a_data_i(a_data), .a_ready_o(a_ready),
        .b_valid_i(b_valid), .b_data_i(b_data), .b_ready_o(b_ready),
        .y_valid_o(y_valid), .y_data_o(y_data), .y_src_o(y_src), .y_ready_i(y_ready)
    );

    mux_rr_arbiter #(.DATA_W(8), .MAX_BURST(1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .a_valid_i(a_valid), .a_data_i(a_data), .a_ready_o(a_ready1),
        .b_valid_i(b_valid), .b_data_i(b_data), .b_ready_o(b_ready1),
        .y_valid_o(y_valid1), .y_data_o(y_data1), .y_src_o(y_src1), .y_ready_i(y_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference grant for the MAX_BURST=4 instance: -1 none, 0 A, 1 B.
    function automatic int mgrant(input logic av, input logic bv);
        if (!av && !bv) return -1;
        if (av != bv) return bv ? 1 : 0;
        if (ms == 0) return 0;
        return (mc >= 4) ? 2 - ms : ms - 1;
    endfunction

    task automatic model_reset();
        ms = 0; mc = 0; my_v = 1'b0; sb.delete();
    endtask

    // Called just after a rising edge; drives one cycle and checks it against the model.
    task automatic step(input logic av, input logic [7:0] ad, input logic bv, input logic [7:0] bd, input logic yr);
        int g;
        bit xfer;
        exp_t e;
        a_valid = av; a_data = ad; b_valid = bv; b_data = bd; y_ready = yr;
        @(negedge clk);
        g = (my_v && !yr) ? -1 : mgrant(av, bv);
        check("a_ready", a_ready, g == 0);
        check("b_ready", b_ready, g == 1);
        xfer = g >= 0;
        if (xfer) begin
            sb.push_back({g == 0 ? ad : bd, g[0]});
            if (ms == g + 1) mc = (mc < 4) ? mc + 1 : mc;
            else begin ms = g + 1; mc = 1; end
            my_v = 1'b1;
        end else if (yr) my_v = 1'b0;
        @(posedge clk); #1;
        check("y_valid", y_valid, my_v);
        if (xfer) begin
            e = sb.pop_front();
            check("y_data", y_data, e.d);
            check("y_src", y_src, e.s);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; a_valid = 0; b_valid = 0; y_ready = 0; a_data = 0; b_data = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 12; i++)
            tbl[i] = '{1'b1, 8'hA0 + 8'(i), 1'b1, 8'hB0 + 8'(i), 1'b1, (i >= 4 && i < 8)};

        // Reset state, then a lone A transfer
        a_valid = 1'b1; a_data = 8'h11; y_ready = 1'b1;
        @(negedge clk);
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_y_valid", y_valid, 0);
        check("rst_y_data", y_data, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        model_reset();
        step(1, 8'h11, 0, 8'h00, 1);
        check("first_y_data", y_data, 8'h11);
        check("first_y_src", y_src, 0);

        // B streams alone
        do_reset();
        for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 8'h20 + 8'(i), 1);

        // Contention with MAX_BURST=4
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].av, tbl[i].ad, tbl[i].bv, tbl[i].bd, tbl[i].yr);
            check("contention_src", y_src, tbl[i].src);
        end

        // Backpressure holds output, readies and FSM; release loads in the same edge
        do_reset();
        step(1, 8'h5A, 0, 8'h00, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 8'h77, 1, 8'h88, 0);
            check("hold_y_data", y_data, 8'h5A);
        end
        step(1, 8'h66, 1, 8'h99, 1);
        check("release_y_data", y_data, 8'h66);
        check("release_y_src", y_src, 0);

        // MAX_BURST=1: strict alternation, then lone A
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 8'hC0 + 8'(i), 1, 8'hD0 + 8'(i), 1);
            check("mb1_alt_src", y_src1, i % 2);
            check("mb1_alt_data", y_data1, (i % 2) ? 8'hD0 + i : 8'hC0 + i);
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 8'hE0 + 8'(i), 0, 8'h00, 1);
            check("mb1_lone_src", y_src1, 0);
            check("mb1_lone_valid", y_valid1, 1);
            check("mb1_lone_data", y_data1, 8'hE0 + i);
        end

        // Reset mid-burst at OWN_B, count 2
        do_reset();
        step(0, 8'h00, 1, 8'hB1, 1);
        step(0, 8'h00, 1, 8'hB2, 1);
        #1 reset_n = 1'b0;
        a_valid = 1; b_valid = 1; a_data = 8'hC1; b_data = 8'hD1;
        #1;
        check("midrst_y_valid", y_valid, 0);
        check("midrst_y_data", y_data, 0);
        check("midrst_y_src", y_src, 0);
        check("midrst_a_ready", a_ready, 0);
        check("midrst_b_ready", b_ready, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        model_reset();
        step(1, 8'hC1, 1, 8'hD1, 1);
        check("postrst_src", y_src, 0);
        check("postrst_data", y_data, 8'hC1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
